// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum output packer.
//   DATA_W_DEF / OUT_W_DEF / PACK_DEF / QDEPTH_DEF / ROWLEN_W_DEF : default widths and depths
//   WORD_W    : packed output word width (PACK_DEF * OUT_W_DEF)
//   q_entry_t : one output-queue entry {last, data}
package psum_pkg;

    localparam int DATA_W_DEF   = 25;
    localparam int OUT_W_DEF    = 8;
    localparam int PACK_DEF     = 4;
    localparam int QDEPTH_DEF   = 4;
    localparam int ROWLEN_W_DEF = 8;
    localparam int WORD_W       = PACK_DEF * OUT_W_DEF;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } q_entry_t;

endpackage

// File: rtl/psum_pack_fifo.sv
// Show-ahead synchronous FIFO holding packed output words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : request to write push_data
//   push_data   : entry to write
//   pop_ready   : downstream ready; a pop happens when the FIFO is not empty
//   head        : entry at the read pointer (valid while !empty)
//   empty       : no entries held
//   count_next  : occupancy after this cycle's push/pop
//   drop        : push refused because the FIFO is full and nothing pops
module psum_pack_fifo #(
    parameter int WIDTH  = 33,
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(QDEPTH):0]  count_next,
    output logic                     drop
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [QDEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(QDEPTH));
    assign pop   = !empty && pop_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;
    assign head  = mem[rd_ptr];

    assign count_next = count + CW'(wr_en) - CW'(pop);

    // queue storage stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/psum_out_packer.sv
// Requantizes ReLU'd partial sums to 8-bit, packs PACK results per word
// (little-endian, last word of a row zero-padded) and queues the words for
// the output-feature-map writer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   stall       : global array stall; in_valid ignored while high
//   in_valid    : in_data valid
//   in_data     : ReLU'd partial sum
//   cfg_shift   : requantization right-shift
//   cfg_rowlen  : results per row (0 treated as 1), sampled at row start
//   out_valid   : a queued word is presented
//   out_ready   : downstream accepts the presented word
//   out_data    : packed word, result k at [k*OUT_W +: OUT_W]
//   out_last    : word closes its row
//   stall_req   : request to freeze the array before the queue overflows
//   ovf_err     : sticky, a completed word was dropped
module psum_out_packer
    import psum_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int PACK     = PACK_DEF,
    parameter int QDEPTH   = QDEPTH_DEF,
    parameter int ROWLEN_W = ROWLEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [4:0]            cfg_shift,
    input  logic [ROWLEN_W-1:0]   cfg_rowlen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PACK*OUT_W-1:0] out_data,
    output logic                  out_last,
    output logic                  stall_req,
    output logic                  ovf_err
);

    localparam int WW = PACK * OUT_W;
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    // Round half up, then shift; kept at DATA_W+1 bits so the rounding carry survives.
    function automatic logic [DATA_W:0] round_shift(input logic [DATA_W-1:0] d,
                                                    input logic [4:0] sh);
        logic [DATA_W:0] rnd;
        rnd = '0;
        if (sh != 5'd0) begin
            rnd = (DATA_W+1)'(1) << (sh - 5'd1);
        end
        return ({1'b0, d} + rnd) >> sh;
    endfunction

    function automatic logic [OUT_W-1:0] saturate(input logic [DATA_W:0] r);
        if (r > (DATA_W+1)'((1 << OUT_W) - 1)) begin
            return '1;
        end
        return r[OUT_W-1:0];
    endfunction

    function automatic logic [ROWLEN_W-1:0] rowlen_eff(input logic [ROWLEN_W-1:0] len);
        return (len == '0) ? ROWLEN_W'(1) : len;
    endfunction

    logic                           acc;
    logic [OUT_W-1:0]               q;
    logic [LW-1:0]                  lane_q;
    logic [ROWLEN_W-1:0]            row_q;
    logic [ROWLEN_W-1:0]            rowlen_q;
    logic [ROWLEN_W-1:0]            rowlen_cur;
    logic [PACK-1:0][OUT_W-1:0]     pack_q;
    logic [PACK-1:0][OUT_W-1:0]     word;
    logic                           eor;
    logic                           lane_last;
    logic                           push;
    logic [WW:0]                    head;
    logic                           empty;
    logic [CW-1:0]                  count_next;
    logic                           drop;

    assign acc = in_valid && !stall;
    // A negative input (MSB set) is clamped to zero regardless of shift.
    assign q   = in_data[DATA_W-1] ? '0 : saturate(round_shift(in_data, cfg_shift));

    // The first result of a row uses the live cfg_rowlen; later ones use the latched copy.
    assign rowlen_cur = (row_q == '0) ? rowlen_eff(cfg_rowlen) : rowlen_q;
    assign eor        = (row_q == rowlen_cur - ROWLEN_W'(1));
    assign lane_last  = (lane_q == LW'(PACK - 1));
    assign push       = acc && (eor || lane_last);

    // Lanes above the current one are already zero because the register clears on push.
    always_comb begin
        word         = pack_q;
        word[lane_q] = q;
    end

    // pack / row stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q    <= '0;
            row_q     <= '0;
            rowlen_q  <= '0;
            pack_q    <= '0;
            stall_req <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (acc) begin
                if (row_q == '0) begin
                    rowlen_q <= rowlen_eff(cfg_rowlen);
                end
                if (push) begin
                    pack_q <= '0;
                    lane_q <= '0;
                end else begin
                    pack_q[lane_q] <= q;
                    lane_q         <= lane_q + LW'(1);
                end
                row_q <= eor ? '0 : row_q + ROWLEN_W'(1);
            end
            // One slot stays free for the word that completes while the stall lands.
            stall_req <= (count_next >= CW'(QDEPTH - 1));
            if (drop) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // output queue stage
    psum_pack_fifo #(
        .WIDTH  (WW + 1),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  ({eor, word}),
        .pop_ready  (out_ready),
        .head       (head),
        .empty      (empty),
        .count_next (count_next),
        .drop       (drop)
    );

    assign out_valid = !empty;
    assign out_last  = head[WW];
    assign out_data  = head[WW-1:0];

endmodule

// File: tb/tb_psum_out_packer.sv
module tb_psum_out_packer;
    import psum_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        in_valid;
    logic [24:0] in_data;
    logic [4:0]  cfg_shift;
    logic [7:0]  cfg_rowlen;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        stall_req;
    logic        ovf_err;

    psum_out_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .cfg_shift  (cfg_shift),
        .cfg_rowlen (cfg_rowlen),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .stall_req  (stall_req),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    q_entry_t sb[$];
    q_entry_t log_q[$];
    q_entry_t pending;
    bit       pend_vld;
    int       m_lane, m_row, m_rowlen;
    logic [3:0][7:0] m_pack;
    bit       m_ovf, m_ovf_next, m_stall, m_stall_next;
    bit       honour;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(input logic [24:0] d, input int sh);
        longint s;
        if (d[24]) return 8'd0;
        s = longint'(d);
        if (sh > 0) s = s + (longint'(1) << (sh - 1));
        s = s & ((longint'(1) << 26) - 1);
        s = s >> sh;
        return (s > 255) ? 8'd255 : s[7:0];
    endfunction

    task automatic model_clear();
        sb.delete();
        log_q.delete();
        pend_vld = 0;
        m_lane = 0; m_row = 0; m_rowlen = 1; m_pack = '0;
        m_ovf = 0; m_ovf_next = 0; m_stall = 0; m_stall_next = 0;
    endtask

    task automatic step(input bit v, input logic [24:0] d, input bit rdy, output bit accepted);
        bit pop, pushw, eor;
        q_entry_t w;
        pushw = 0;
        w = '0;
        @(posedge clk); #1;
        if (pend_vld) sb.push_back(pending);
        pend_vld = 0;
        m_ovf   = m_ovf_next;
        m_stall = m_stall_next;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        stall     = honour ? stall_req : 1'b0;
        accepted  = v && !stall;
        if (accepted) begin
            if (m_row == 0) m_rowlen = (cfg_rowlen == 0) ? 1 : int'(cfg_rowlen);
            m_pack[m_lane] = ref_q(d, int'(cfg_shift));
            eor = (m_row == m_rowlen - 1);
            if (eor || m_lane == 3) begin
                w.last = eor; w.data = m_pack; pushw = 1;
                m_pack = '0; m_lane = 0;
            end else begin
                m_lane++;
            end
            m_row = eor ? 0 : m_row + 1;
        end
        pop = (sb.size() != 0) && rdy;
        if (pushw) begin
            if (sb.size() == 4 && !pop) m_ovf_next = 1;
            else begin pending = w; pend_vld = 1; end
        end
        m_stall_next = (int'(sb.size()) - int'(pop) + int'(pend_vld)) >= 3;
        @(negedge clk);
        check("out_valid", out_valid, sb.size() != 0);
        check("stall_req", stall_req, m_stall);
        check("ovf_err", ovf_err, m_ovf);
        if (pop) begin
            check("out_data", out_data, sb[0].data);
            check("out_last", out_last, sb[0].last);
            log_q.push_back(sb.pop_front());
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 25'd0, rdy, a);
    endtask

    task automatic check_log(input string tag, input int idx, input logic last, input logic [31:0] data);
        q_entry_t e;
        e = '0;
        if (idx < log_q.size()) e = log_q[idx];
        check({tag, "_data"}, e.data, data);
        check({tag, "_last"}, e.last, last);
    endtask

    initial begin
        bit a;
        int idx;
        int guard;
        rst_n = 1'b0; stall = 0; in_valid = 0; in_data = '0;
        cfg_shift = '0; cfg_rowlen = 8'd8; out_ready = 0; honour = 0;
        model_clear();
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_stall_req", stall_req, 1'b0);
        check("rst_ovf_err", ovf_err, 1'b0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 1: back-to-back 1..8, row of 8
        cfg_shift = 5'd0; cfg_rowlen = 8'd8;
        for (int i = 1; i <= 8; i++) step(1'b1, 25'(i), 1'b1, a);
        idle(3, 1'b1);
        check("t1_count", log_q.size(), 2);
        check_log("t1_w0", 0, 1'b0, 32'h04030201);
        check_log("t1_w1", 1, 1'b1, 32'h08070605);
        log_q.delete();

        // 2: rounding, saturation, defensive ReLU
        cfg_shift = 5'd4; cfg_rowlen = 8'd4;
        step(1'b1, 25'h18, 1'b1, a);
        step(1'b1, 25'h100000, 1'b1, a);
        step(1'b1, 25'h1000010, 1'b1, a);
        step(1'b1, 25'h7, 1'b1, a);
        idle(3, 1'b1);
        check("t2_count", log_q.size(), 1);
        check_log("t2_w0", 0, 1'b1, 32'h0000FF02);
        log_q.delete();

        // 3: row of 6 with zero-padded tail, next row starts at lane 0
        cfg_shift = 5'd0; cfg_rowlen = 8'd6;
        for (int i = 1; i <= 6; i++) step(1'b1, 25'(i), 1'b1, a);
        for (int i = 9; i <= 14; i++) step(1'b1, 25'(i), 1'b1, a);
        idle(3, 1'b1);
        check("t3_count", log_q.size(), 4);
        check_log("t3_w0", 0, 1'b0, 32'h04030201);
        check_log("t3_w1", 1, 1'b1, 32'h00000605);
        check_log("t3_w2", 2, 1'b0, 32'h0C0B0A09);
        check_log("t3_w3", 3, 1'b1, 32'h00000E0D);
        log_q.delete();

        // 4: backpressure with stall honoured
        cfg_rowlen = 8'd16; honour = 1;
        idx = 1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 25'(idx), 1'b0, a);
            if (a) idx++;
        end
        check("t4_stall_held", stall_req, 1'b1);
        check("t4_accepted", idx, 13);
        check("t4_no_ovf", ovf_err, 1'b0);
        guard = 0;
        while ((idx <= 16 || sb.size() != 0 || pend_vld) && guard < 80) begin
            step(idx <= 16, 25'(idx), 1'b1, a);
            if (a) idx++;
            guard++;
        end
        check("t4_drain_timeout", guard < 80, 1'b1);
        idle(2, 1'b1);
        check("t4_stall_fell", stall_req, 1'b0);
        check("t4_count", log_q.size(), 4);
        check_log("t4_w0", 0, 1'b0, 32'h04030201);
        check_log("t4_w3", 3, 1'b1, 32'h100F0E0D);
        log_q.delete();

        // 5: stall ignored -> fifth word dropped
        honour = 0; cfg_rowlen = 8'd200;
        for (int i = 1; i <= 20; i++) step(1'b1, 25'(i), 1'b0, a);
        idle(1, 1'b0);
        check("t5_ovf", ovf_err, 1'b1);
        check("t5_head", out_data, 32'h04030201);
        idle(6, 1'b1);
        check("t5_count", log_q.size(), 4);
        check_log("t5_w2", 2, 1'b0, 32'h0C0B0A09);
        check_log("t5_w3", 3, 1'b0, 32'h100F0E0D);
        log_q.delete();

        // 6: reset mid-word with two words queued
        for (int i = 1; i <= 10; i++) step(1'b1, 25'(i + 32), 1'b0, a);
        check("t6_queued", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_out_data", out_data, 32'd0);
        check("t6_out_last", out_last, 1'b0);
        check("t6_stall_req", stall_req, 1'b0);
        check("t6_ovf_err", ovf_err, 1'b0);
        model_clear();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        in_valid = 0;
        cfg_rowlen = 8'd8;
        for (int i = 1; i <= 4; i++) step(1'b1, 25'(i + 48), 1'b1, a);
        idle(3, 1'b1);
        check("t6_count", log_q.size(), 1);
        check_log("t6_w0", 0, 1'b0, 32'h34333231);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
